// File: rtl/booth_r8_mac_seq.sv
// Iterative radix-8 Booth multiplier/accumulator.
// One Booth digit per cycle, start/done handshake, abortable.
module booth_r8_mac_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               acc_en,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [1:0]         sign_mode,
  output logic [2*WIDTH-1:0] product,
  output logic               done,
  output logic               busy
);

  localparam int DIGITS = (WIDTH + 3) / 3;
  localparam int PW = 2 * WIDTH;
  localparam int BW = 3 * DIGITS + 1;
  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE, PREP, ITER, FINISH
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]     cnt;
  logic [PW-1:0]     a_sh;
  logic [PW-1:0]     a3_sh;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     mult;
  logic [BW-1:0]     b_sh;
  logic              acc_mode;
  logic signed [WIDTH:0] a_ext;
  logic signed [WIDTH:0] b_ext;
  logic              accept;
  logic              write;
  logic              last;

  assign a_ext = {sign_mode[1] & multiplicand[WIDTH-1],
                  multiplicand};
  assign b_ext = {sign_mode[0] & multiplier[WIDTH-1],
                  multiplier};
  assign last  = (cnt == CW'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_nx = PREP;
        PREP:    state_nx = ITER;
        ITER:    if (last) state_nx = FINISH;
        FINISH:  state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = (state != IDLE);
    accept = (state == IDLE) && start && !abort;
    write  = (state == FINISH) && !abort;
  end

  // Window is {b[3k+2], b[3k+1], b[3k], b[3k-1]}
  always_comb begin
    mult = '0;
    unique case (b_sh[3:0])
      4'b0000, 4'b1111: mult = '0;
      4'b0001, 4'b0010: mult = a_sh;
      4'b0011, 4'b0100: mult = a_sh << 1;
      4'b0101, 4'b0110: mult = a3_sh;
      4'b0111:          mult = a_sh << 2;
      4'b1000:          mult = -(a_sh << 2);
      4'b1001, 4'b1010: mult = -a3_sh;
      4'b1011, 4'b1100: mult = -(a_sh << 1);
      4'b1101, 4'b1110: mult = -a_sh;
      default:          mult = '0;
    endcase
  end

  // Multiples are pre-weighted by 8^k: A and 3A shift left each digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product  <= '0;
      done     <= 1'b0;
      cnt      <= '0;
      a_sh     <= '0;
      a3_sh    <= '0;
      acc      <= '0;
      b_sh     <= '0;
      acc_mode <= 1'b0;
    end else begin
      done <= write;
      if (accept) begin
        a_sh     <= PW'(a_ext);
        a3_sh    <= '0;
        b_sh     <= {(BW-1)'(b_ext), 1'b0};
        acc      <= '0;
        cnt      <= '0;
        acc_mode <= acc_en;
      end
      if (state == PREP) begin
        a3_sh <= a_sh + (a_sh << 1);
      end
      if (state == ITER) begin
        acc   <= acc + mult;
        a_sh  <= a_sh << 3;
        a3_sh <= a3_sh << 3;
        b_sh  <= b_sh >> 3;
        cnt   <= cnt + 1'b1;
      end
      if (write) begin
        product <= acc_mode ? product + acc : acc;
      end
    end
  end

endmodule

// File: tb/tb_booth_r8_mac_seq.sv
// Bench for booth_r8_mac_seq: WIDTH=8 and WIDTH=16 instances,
// spec vectors, corner/random sweeps against an integer model.
module tb_booth_r8_mac_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        st8, ab8, ac8, d8, busy8;
  logic [1:0]  sm8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        st16, ab16, ac16, d16, busy16;
  logic [1:0]  sm16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  booth_r8_mac_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .abort(ab8),
    .acc_en(ac8), .multiplicand(a8), .multiplier(b8),
    .sign_mode(sm8), .product(p8), .done(d8), .busy(busy8)
  );

  booth_r8_mac_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .abort(ab16),
    .acc_en(ac16), .multiplicand(a16), .multiplier(b16),
    .sign_mode(sm16), .product(p16), .done(d16),
    .busy(busy16)
  );

  typedef struct {
    int          w;
    logic [1:0]  sm;
    logic        ac;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  int nvec = 0;
  int nerr = 0;
  logic [63:0] mp [2];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic st,
                       input logic ab, input logic ac,
                       input logic [1:0] sm,
                       input logic [31:0] a,
                       input logic [31:0] b);
    if (w == 8) begin
      st8 = st; ab8 = ab; ac8 = ac; sm8 = sm;
      a8 = a[7:0]; b8 = b[7:0];
    end else begin
      st16 = st; ab16 = ab; ac16 = ac; sm16 = sm;
      a16 = a[15:0]; b16 = b[15:0];
    end
  endtask

  function automatic logic [63:0] prod_of(input int w);
    if (w == 8) return {48'd0, p8};
    return {32'd0, p16};
  endfunction

  function automatic logic done_of(input int w);
    return (w == 8) ? d8 : d16;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction

  // Exact (WIDTH+1)-bit product, truncated to 2*WIDTH bits
  function automatic logic [63:0] model_raw(
      input int w, input logic [1:0] sm,
      input logic [31:0] a, input logic [31:0] b);
    longint m, av, bv;
    m  = (longint'(1) << w) - 1;
    av = longint'(a) & m;
    bv = longint'(b) & m;
    if (sm[1] && a[w-1]) av = av - (longint'(1) << w);
    if (sm[0] && b[w-1]) bv = bv - (longint'(1) << w);
    return 64'(av * bv) & ((64'd1 << (2 * w)) - 1);
  endfunction

  task automatic count_done(input int w, input int n,
                            output int c);
    c = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done_of(w)) c++;
    end
  endtask

  task automatic run_op(input string nm, input int w,
                        input logic [1:0] sm, input logic ac,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic scr, input logic use_exp,
                        input logic [63:0] expv);
    int ix, lat, dig;
    logic [63:0] r, e, pm;
    ix  = (w == 16) ? 1 : 0;
    dig = (w + 3) / 3;
    pm  = (64'd1 << (2 * w)) - 1;
    r   = model_raw(w, sm, a, b);
    e   = ac ? ((mp[ix] + r) & pm) : r;
    if (use_exp) e = expv;
    @(negedge clk);
    drive(w, 1'b1, 1'b0, ac, sm, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    chk({nm, " busy"}, 64'(busy_of(w)), 64'd1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (scr)
        drive(w, 1'b0, 1'b0, 1'($urandom), 2'($urandom),
              $urandom, $urandom);
      @(posedge clk); #1;
      if (done_of(w)) begin
        lat = i;
        break;
      end
    end
    chk({nm, " latency"}, 64'(lat), 64'(dig + 2));
    chk({nm, " product"}, prod_of(w), e);
    chk({nm, " busy@done"}, 64'(busy_of(w)), 64'd0);
    @(posedge clk); #1;
    chk({nm, " done width"}, 64'(done_of(w)), 64'd0);
    drive(w, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    mp[ix] = e;
  endtask

  vec_t tv [9];
  logic [31:0] cv [8];

  initial begin
    int c;
    int q [$];
    tv[0] = '{8,  2'b11, 1'b0, 32'h80,   32'h80,   64'h4000};
    tv[1] = '{8,  2'b00, 1'b0, 32'hFF,   32'hFF,   64'hFE01};
    tv[2] = '{8,  2'b01, 1'b0, 32'hFF,   32'h80,   64'h8080};
    tv[3] = '{8,  2'b10, 1'b0, 32'h80,   32'hFF,   64'h8080};
    tv[4] = '{16, 2'b11, 1'b0, 32'h8000, 32'h7FFF,
              64'hC0008000};
    tv[5] = '{8,  2'b00, 1'b0, 32'd3,    32'd5,    64'h000F};
    tv[6] = '{8,  2'b00, 1'b1, 32'd7,    32'd2,    64'h001D};
    tv[7] = '{8,  2'b11, 1'b1, 32'hFF,   32'h01,   64'h001C};
    tv[8] = '{8,  2'b00, 1'b0, 32'h1D,   32'h01,   64'h001D};
    cv = '{32'h0, 32'h1, 32'h7FFF, 32'h8000,
           32'hFFFF, 32'hAAAA, 32'h5555, 32'h2};
    mp[0] = '0;
    mp[1] = '0;

    rst_n = 1'b0;
    drive(8,  1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    drive(16, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst p8", prod_of(8), 64'd0);
    chk("rst d8", 64'(d8), 64'd0);
    chk("rst busy8", 64'(busy8), 64'd0);
    chk("rst p16", prod_of(16), 64'd0);
    chk("rst busy16", 64'(busy16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), tv[i].w, tv[i].sm,
             tv[i].ac, tv[i].a, tv[i].b, 1'b0, 1'b1,
             tv[i].exp);

    // Abort two edges after accept; product must stay 0x1D
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 1'b0, 2'b00, 32'h10, 32'h10);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    @(posedge clk); #1;
    ab8 = 1'b1;
    @(posedge clk); #1;
    ab8 = 1'b0;
    chk("abort busy", 64'(busy8), 64'd0);
    chk("abort done", 64'(d8), 64'd0);
    count_done(8, 10, c);
    chk("abort no done", 64'(c), 64'd0);
    chk("abort product", prod_of(8), 64'h1D);
    run_op("after abort", 8, 2'b00, 1'b1, 32'd3, 32'd3,
           1'b0, 1'b0, 64'd0);

    // Abort coincident with the FINISH edge
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 1'b1, 2'b00, 32'd9, 32'd9);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    ab8 = 1'b1;
    @(posedge clk); #1;
    ab8 = 1'b0;
    chk("abort fin done", 64'(d8), 64'd0);
    chk("abort fin busy", 64'(busy8), 64'd0);
    count_done(8, 8, c);
    chk("abort fin no done", 64'(c), 64'd0);
    chk("abort fin product", prod_of(8), mp[0]);

    // Abort and start together in IDLE
    @(negedge clk);
    drive(8, 1'b1, 1'b1, 1'b0, 2'b00, 32'd4, 32'd4);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    chk("abort+start busy", 64'(busy8), 64'd0);
    count_done(8, 8, c);
    chk("abort+start no done", 64'(c), 64'd0);

    // start held high: back-to-back issue, no queuing
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 1'b1, 2'b00, 32'd5, 32'd6);
    @(posedge clk); #1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (d8) q.push_back(i);
      if (i == 6)
        drive(8, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    end
    mp[0] = (mp[0] + 64'd60) & 64'hFFFF;
    chk("b2b done count", 64'(q.size()), 64'd2);
    if (q.size() == 2) begin
      chk("b2b first", 64'(q[0]), 64'd5);
      chk("b2b second", 64'(q[1]), 64'd11);
    end
    chk("b2b product", prod_of(8), mp[0]);

    // Operands scrambled while in flight
    for (int i = 0; i < 4; i++) begin
      run_op("scramble8", 8, 2'($urandom), 1'($urandom),
             $urandom, $urandom, 1'b1, 1'b0, 64'd0);
      run_op("scramble16", 16, 2'($urandom), 1'($urandom),
             $urandom, $urandom, 1'b1, 1'b0, 64'd0);
    end

    for (int m = 0; m < 4; m++)
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++)
          run_op($sformatf("corner m%0d %0d,%0d", m, i, j),
                 16, 2'(m), 1'b0, cv[i], cv[j],
                 1'b0, 1'b0, 64'd0);

    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 200; i++)
        run_op($sformatf("rnd16 m%0d #%0d", m, i), 16,
               2'(m), 1'($urandom), $urandom, $urandom,
               1'b0, 1'b0, 64'd0);
      for (int i = 0; i < 50; i++)
        run_op($sformatf("rnd8 m%0d #%0d", m, i), 8,
               2'(m), 1'($urandom), $urandom, $urandom,
               1'b0, 1'b0, 64'd0);
    end

    // Reset pulled mid-ITER
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 1'b0, 2'b00, 32'hF3, 32'hE7);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst product", prod_of(8), 64'd0);
    chk("midrst done", 64'(d8), 64'd0);
    chk("midrst busy", 64'(busy8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mp[0] = '0;
    mp[1] = '0;
    run_op("post reset", 8, 2'b00, 1'b1, 32'd11, 32'd13,
           1'b0, 1'b0, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
